// File: rtl/extbus_ctl.sv
// Slot manager and port arbiter for the four-word, four-port external-bus mailbox.
// It tracks slot occupancy, destination and age, and drives the buffer's per-port address, enable and write-enable.
module extbus_ctl (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] wr,
    input  logic [7:0] dst,
    output logic [3:0] gnt,
    output logic [3:0] avail,
    output logic [3:0] full,
    output logic [1:0] AA,
    output logic [1:0] AB,
    output logic [1:0] AC,
    output logic [1:0] AX,
    output logic       ECA,
    output logic       ECB,
    output logic       ECC,
    output logic       ECX,
    output logic       WA,
    output logic       WB,
    output logic       WC,
    output logic       WX
);

    logic [3:0] r_full;
    logic [1:0] r_dst   [4];
    logic [3:0] r_older [4];
    logic [3:0] r_gnt;
    logic [3:0] r_we;
    logic [3:0] r_avail;
    logic [1:0] r_addr  [4];

    logic [3:0] w_full;
    logic [1:0] w_dst   [4];
    logic [3:0] w_older [4];
    logic [3:0] w_gnt;
    logic [3:0] w_we;
    logic [3:0] w_avail;
    logic [1:0] w_addr  [4];
    logic [3:0] w_taken;
    logic       w_found;
    logic       w_blocked;

    // Gets are resolved first. Puts only see slots that were empty at the start of the cycle.
    always_comb begin
        w_full    = r_full;
        w_dst     = r_dst;
        w_older   = r_older;
        w_gnt     = 4'b0000;
        w_we      = 4'b0000;
        w_avail   = 4'b0000;
        w_taken   = 4'b0000;
        w_found   = 1'b0;
        w_blocked = 1'b0;
        for (int p = 0; p < 4; p++) begin
            w_addr[p] = 2'd0;
        end

        for (int p = 0; p < 4; p++) begin
            if (req[p] && !wr[p]) begin
                w_found = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    w_blocked = 1'b0;
                    for (int j = 0; j < 4; j++) begin
                        if (r_full[j] && (r_dst[j] == 2'(p)) && r_older[j][s]) begin
                            w_blocked = 1'b1;
                        end
                    end
                    if (!w_found && r_full[s] && (r_dst[s] == 2'(p)) && !w_blocked) begin
                        w_found    = 1'b1;
                        w_gnt[p]   = 1'b1;
                        w_addr[p]  = 2'(s);
                        w_full[s]  = 1'b0;
                        w_older[s] = 4'b0000;
                        for (int j = 0; j < 4; j++) begin
                            w_older[j][s] = 1'b0;
                        end
                    end
                end
            end
        end

        // Earlier puts in this loop are already marked full, so they count as older than later ones.
        for (int p = 0; p < 4; p++) begin
            if (req[p] && wr[p]) begin
                w_found = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    if (!w_found && !r_full[s] && !w_taken[s]) begin
                        w_found    = 1'b1;
                        w_taken[s] = 1'b1;
                        w_gnt[p]   = 1'b1;
                        w_we[p]    = 1'b1;
                        w_addr[p]  = 2'(s);
                        for (int j = 0; j < 4; j++) begin
                            if (w_full[j]) begin
                                w_older[j][s] = 1'b1;
                            end
                        end
                        w_older[s] = 4'b0000;
                        w_full[s]  = 1'b1;
                        w_dst[s]   = dst[2*p +: 2];
                    end
                end
            end
        end

        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < 4; s++) begin
                if (w_full[s] && (w_dst[s] == 2'(p))) begin
                    w_avail[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full  <= 4'b0000;
            r_gnt   <= 4'b0000;
            r_we    <= 4'b0000;
            r_avail <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_dst[i]   <= 2'd0;
                r_older[i] <= 4'b0000;
                r_addr[i]  <= 2'd0;
            end
        end else begin
            r_full  <= w_full;
            r_gnt   <= w_gnt;
            r_we    <= w_we;
            r_avail <= w_avail;
            for (int i = 0; i < 4; i++) begin
                r_dst[i]   <= w_dst[i];
                r_older[i] <= w_older[i];
                r_addr[i]  <= w_addr[i];
            end
        end
    end

    // Every grant enables its port for one cycle. Only puts also raise the write enable.
    assign gnt   = r_gnt;
    assign avail = r_avail;
    assign full  = r_full;
    assign ECA   = r_gnt[0];
    assign ECB   = r_gnt[1];
    assign ECC   = r_gnt[2];
    assign ECX   = r_gnt[3];
    assign WA    = r_we[0];
    assign WB    = r_we[1];
    assign WC    = r_we[2];
    assign WX    = r_we[3];
    assign AA    = r_addr[0];
    assign AB    = r_addr[1];
    assign AC    = r_addr[2];
    assign AX    = r_addr[3];

endmodule

// File: tb/tb_extbus_ctl.sv
// Self-checking bench for extbus_ctl. A mailbox model keeps one FIFO queue per destination and a set of free slots.
// Directed scenarios pin literal values, and randomized traffic is compared with the model every cycle.
module tb_extbus_ctl;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] wr;
    logic [7:0] dst;
    logic [3:0] gnt;
    logic [3:0] avail;
    logic [3:0] full;
    logic [1:0] AA, AB, AC, AX;
    logic       ECA, ECB, ECC, ECX;
    logic       WA, WB, WC, WX;

    int checks = 0;
    int errors = 0;

    int fifoSlot [4][4];
    int fifoCnt  [4];
    bit mFull    [4];

    logic [3:0] eGnt;
    logic [3:0] eW;
    logic [3:0] eFull;
    logic [3:0] eAvail;
    logic [1:0] eA [4];

    extbus_ctl dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wr    (wr),
        .dst   (dst),
        .gnt   (gnt),
        .avail (avail),
        .full  (full),
        .AA    (AA),
        .AB    (AB),
        .AC    (AC),
        .AX    (AX),
        .ECA   (ECA),
        .ECB   (ECB),
        .ECC   (ECC),
        .ECX   (ECX),
        .WA    (WA),
        .WB    (WB),
        .WC    (WC),
        .WX    (WX)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        chk("gnt",   {4'd0, gnt},   {4'd0, eGnt});
        chk("full",  {4'd0, full},  {4'd0, eFull});
        chk("avail", {4'd0, avail}, {4'd0, eAvail});
        chk("ec",    {4'd0, ECX, ECC, ECB, ECA}, {4'd0, eGnt});
        chk("we",    {4'd0, WX, WC, WB, WA},     {4'd0, eW});
        chk("AA", {6'd0, AA}, {6'd0, eA[0]});
        chk("AB", {6'd0, AB}, {6'd0, eA[1]});
        chk("AC", {6'd0, AC}, {6'd0, eA[2]});
        chk("AX", {6'd0, AX}, {6'd0, eA[3]});
    endtask

    // Drives one cycle of inputs and advances the mailbox model to the outputs expected after the next edge.
    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic [3:0] w, input logic [7:0] d);
        bit freeAtStart [4];
        bit found;
        int s;
        int dp;
        reset = rst;
        req   = r;
        wr    = w;
        dst   = d;
        eGnt  = 4'b0000;
        eW    = 4'b0000;
        for (int i = 0; i < 4; i++) eA[i] = 2'd0;
        if (rst) begin
            for (int p = 0; p < 4; p++) begin
                fifoCnt[p] = 0;
                mFull[p]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) freeAtStart[i] = !mFull[i];
            for (int p = 0; p < 4; p++) begin
                if (r[p] && !w[p] && fifoCnt[p] > 0) begin
                    s = fifoSlot[p][0];
                    for (int k = 0; k < 3; k++) fifoSlot[p][k] = fifoSlot[p][k+1];
                    fifoCnt[p]--;
                    mFull[s] = 1'b0;
                    eGnt[p]  = 1'b1;
                    eA[p]    = 2'(s);
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (r[p] && w[p]) begin
                    found = 1'b0;
                    for (int s2 = 0; s2 < 4; s2++) begin
                        if (!found && freeAtStart[s2]) begin
                            found           = 1'b1;
                            freeAtStart[s2] = 1'b0;
                            mFull[s2]       = 1'b1;
                            dp              = int'(d[2*p +: 2]);
                            fifoSlot[dp][fifoCnt[dp]] = s2;
                            fifoCnt[dp]++;
                            eGnt[p] = 1'b1;
                            eW[p]   = 1'b1;
                            eA[p]   = 2'(s2);
                        end
                    end
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            eFull[p]  = mFull[p];
            eAvail[p] = (fifoCnt[p] > 0);
        end
    endtask

    task automatic cyc(input logic rst, input logic [3:0] r, input logic [3:0] w, input logic [7:0] d);
        applyStimulus(rst, r, w, d);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        logic [3:0] rr;
        logic [3:0] ww;
        logic [7:0] dd;
        logic       rs;

        $display("[TB] start");
        cyc(1'b1, 4'b0000, 4'b0000, 8'h00);
        chk("rst_gnt",  {4'd0, gnt},  8'h00);
        chk("rst_full", {4'd0, full}, 8'h00);
        repeat (3) begin
            cyc(1'b0, 4'b0000, 4'b0000, 8'h00);
            chk("idle_gnt",   {4'd0, gnt},   8'h00);
            chk("idle_full",  {4'd0, full},  8'h00);
            chk("idle_avail", {4'd0, avail}, 8'h00);
            chk("idle_ec",    {4'd0, ECX, ECC, ECB, ECA}, 8'h00);
            chk("idle_we",    {4'd0, WX, WC, WB, WA},     8'h00);
        end

        // A puts a word for B, and B then collects it.
        cyc(1'b0, 4'b0001, 4'b0001, 8'h01);
        chk("aput_gnt", {4'd0, gnt}, 8'h01);
        chk("aput_eca", {7'd0, ECA}, 8'h01);
        chk("aput_wa",  {7'd0, WA},  8'h01);
        chk("aput_aa",  {6'd0, AA},  8'h00);
        cyc(1'b0, 4'b0000, 4'b0000, 8'h00);
        chk("aput_full",  {4'd0, full},  8'h01);
        chk("aput_avail", {4'd0, avail}, 8'h02);
        cyc(1'b0, 4'b0010, 4'b0000, 8'h00);
        chk("bget_ecb", {7'd0, ECB}, 8'h01);
        chk("bget_wb",  {7'd0, WB},  8'h00);
        chk("bget_ab",  {6'd0, AB},  8'h00);
        cyc(1'b0, 4'b0000, 4'b0000, 8'h00);
        chk("bget_full", {4'd0, full}, 8'h00);

        // Words for C come back in the order they were put.
        cyc(1'b0, 4'b0001, 4'b0001, 8'h02);
        cyc(1'b0, 4'b0001, 4'b0001, 8'h02);
        cyc(1'b0, 4'b1000, 4'b1000, 8'h80);
        chk("xput_ax", {6'd0, AX}, 8'h02);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'b0100, 4'b0000, 8'h00);
            chk("cget_ecc", {7'd0, ECC}, 8'h01);
            chk("cget_ac",  {6'd0, AC},  8'(k));
        end
        cyc(1'b0, 4'b0000, 4'b0000, 8'h00);
        chk("cget_full", {4'd0, full}, 8'h00);

        // Four puts in one cycle take ascending slots in priority order.
        cyc(1'b0, 4'b1111, 4'b1111, 8'h00);
        chk("all_gnt", {4'd0, gnt}, 8'h0f);
        chk("all_aa", {6'd0, AA}, 8'h00);
        chk("all_ab", {6'd0, AB}, 8'h01);
        chk("all_ac", {6'd0, AC}, 8'h02);
        chk("all_ax", {6'd0, AX}, 8'h03);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'b0001, 4'b0000, 8'h00);
            chk("aget_aa", {6'd0, AA}, 8'(k));
        end

        // With the buffer full, a get and a put in the same cycle grant only the get.
        cyc(1'b0, 4'b1111, 4'b1111, 8'h00);
        cyc(1'b0, 4'b0011, 4'b0010, 8'h08);
        chk("fullmix_gnt", {4'd0, gnt}, 8'h01);
        chk("fullmix_aa",  {6'd0, AA},  8'h00);
        cyc(1'b0, 4'b0010, 4'b0010, 8'h08);
        chk("reuse_gnt", {4'd0, gnt}, 8'h02);
        chk("reuse_ab",  {6'd0, AB},  8'h00);
        chk("reuse_wb",  {7'd0, WB},  8'h01);

        // A reset on a grant cycle drops the stored words and the pending grant.
        cyc(1'b1, 4'b0000, 4'b0000, 8'h00);
        cyc(1'b0, 4'b0001, 4'b0001, 8'h01);
        cyc(1'b0, 4'b0001, 4'b0001, 8'h01);
        cyc(1'b1, 4'b0000, 4'b0000, 8'h00);
        chk("midrst_full", {4'd0, full}, 8'h00);
        chk("midrst_gnt",  {4'd0, gnt},  8'h00);
        repeat (10) begin
            cyc(1'b0, 4'b0010, 4'b0000, 8'h00);
            chk("postrst_gnt", {4'd0, gnt}, 8'h00);
        end

        // Random traffic, with an occasional reset.
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 199) == 0);
            rr = 4'($urandom);
            ww = 4'($urandom);
            dd = 8'($urandom);
            cyc(rs, rr, ww, dd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
